// File: rtl/llc_responder.sv
// rtl/llc_responder.sv - LLC line responder: in-order request FIFO, fixed-latency backing store, held response
// Optional feature macro LLC_RESP_WRITE_ACK_EN: write requests also return a response carrying the written line.
module llc_responder #(
  parameter int CACHE_LINE_BYTES = 64,
  parameter int MEM_LINES        = 64,
  parameter int LATENCY          = 5,
  parameter int REQ_Q_DEPTH      = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          req_valid_in,
  output logic                          req_ready_out,
  input  logic [63:0]                   req_addr_in,
  input  logic                          req_we_in,
  input  logic [CACHE_LINE_BYTES*8-1:0] req_value_in,
  output logic                          resp_valid_out,
  input  logic                          resp_ready_in,
  output logic [63:0]                   resp_addr_out,
  output logic [CACHE_LINE_BYTES*8-1:0] resp_value_out,
  input  logic                          init_we_in,
  input  logic [$clog2(MEM_LINES)-1:0]  init_line_in,
  input  logic [CACHE_LINE_BYTES*8-1:0] init_value_in
);
  localparam int LW   = CACHE_LINE_BYTES * 8;
  localparam int OFFW = $clog2(CACHE_LINE_BYTES);
  localparam int IW   = $clog2(MEM_LINES);
  localparam int PW   = (REQ_Q_DEPTH > 1) ? $clog2(REQ_Q_DEPTH) : 1;
  localparam int CW   = $clog2(REQ_Q_DEPTH + 1);
`ifdef LLC_RESP_WRITE_ACK_EN
  localparam bit ACK_WRITES = 1'b1;
`else
  localparam bit ACK_WRITES = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;
  state_t state, state_nxt;

  logic [LW-1:0] mem     [MEM_LINES];
  logic [63:0]   q_addr  [REQ_Q_DEPTH];
  logic          q_we    [REQ_Q_DEPTH];
  logic [LW-1:0] q_value [REQ_Q_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic [63:0]   cur_addr;
  logic          cur_we;
  logic [LW-1:0] cur_value;
  logic [7:0]    cnt;

  logic          push, pop, capture, not_empty;
  logic          head_in_range, cur_in_range;
  logic [63:0]   head_line, cur_line;

  assign not_empty     = (count != '0);
  assign req_ready_out = (count != CW'(REQ_Q_DEPTH));
  assign push          = req_valid_in && req_ready_out;
  assign head_line     = q_addr[rd_ptr] >> OFFW;
  assign cur_line      = cur_addr >> OFFW;
  assign head_in_range = (head_line < 64'(MEM_LINES));
  assign cur_in_range  = (cur_line < 64'(MEM_LINES));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // An unacknowledged write only needs the pop cycle, so it leaves WAIT immediately.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (not_empty) state_nxt = WAIT;
      WAIT: begin
        if (cur_we && !ACK_WRITES) state_nxt = IDLE;
        else if (cnt == 8'd0)      state_nxt = SEND;
      end
      SEND: if (resp_ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    resp_valid_out = 1'b0;
    pop            = 1'b0;
    capture        = 1'b0;
    case (state)
      IDLE: pop = not_empty;
      WAIT: capture = (cnt == 8'd0) && !(cur_we && !ACK_WRITES);
      SEND: resp_valid_out = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      q_addr[wr_ptr]  <= req_addr_in;
      q_we[wr_ptr]    <= req_we_in;
      q_value[wr_ptr] <= req_value_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(REQ_Q_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(REQ_Q_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Request writes come after init writes so they win on a same-line collision.
  always_ff @(posedge clk_in) begin
    if (init_we_in) mem[init_line_in] <= init_value_in;
    if (!rst_in && pop && q_we[rd_ptr] && head_in_range)
      mem[head_line[IW-1:0]] <= q_value[rd_ptr];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt            <= 8'd0;
      cur_addr       <= '0;
      cur_we         <= 1'b0;
      cur_value      <= '0;
      resp_addr_out  <= '0;
      resp_value_out <= '0;
    end else begin
      if (pop) begin
        cur_addr  <= q_addr[rd_ptr];
        cur_we    <= q_we[rd_ptr];
        cur_value <= q_value[rd_ptr];
        cnt       <= 8'(LATENCY);
      end else if (state == WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (capture) begin
        resp_addr_out  <= cur_addr;
        resp_value_out <= cur_we ? cur_value :
                          (cur_in_range ? mem[cur_line[IW-1:0]] : '0);
      end
    end
  end
endmodule

// File: tb/tb_llc_responder.sv
// tb/tb_llc_responder.sv - directed and randomized checks of llc_responder against a line-level memory model
module tb_llc_responder;
  localparam int LW    = 512;
  localparam int LINES = 64;
  localparam int LAT   = 5;

  logic          clk = 1'b0;
  logic          rst, req_valid, req_ready, req_we, resp_valid, resp_ready, init_we;
  logic [63:0]   req_addr, resp_addr;
  logic [LW-1:0] req_value, resp_value, init_value;
  logic [5:0]    init_line;

  int total = 0;
  int bad   = 0;
  logic [LW-1:0] model_mem [LINES];
  logic [63:0]   exp_addr [$];
  logic [LW-1:0] exp_val  [$];

  llc_responder #(.CACHE_LINE_BYTES(64), .MEM_LINES(LINES), .LATENCY(LAT), .REQ_Q_DEPTH(2)) dut (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid), .req_ready_out(req_ready), .req_addr_in(req_addr),
    .req_we_in(req_we), .req_value_in(req_value),
    .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
    .resp_addr_out(resp_addr), .resp_value_out(resp_value),
    .init_we_in(init_we), .init_line_in(init_line), .init_value_in(init_value)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [LW-1:0] model_read(input logic [63:0] a);
    logic [63:0] line;
    line = a >> 6;
    return (line < LINES) ? model_mem[line[5:0]] : '0;
  endfunction

  function automatic logic [63:0] rand_addr();
    return (64'($urandom_range(0, LINES + 7)) << 6) | 64'($urandom_range(0, 63));
  endfunction

  task automatic do_init(input int line, input logic [LW-1:0] v);
    init_we = 1'b1; init_line = 6'(line); init_value = v;
    tick();
    init_we = 1'b0;
    model_mem[line] = v;
  endtask

  task automatic send_req(input logic [63:0] a, input logic we, input logic [LW-1:0] v);
    int g = 0;
    req_valid = 1'b1; req_addr = a; req_we = we; req_value = v;
    while (!req_ready && g < 100) begin tick(); g++; end
    check("req_accept", req_ready, 1);
    tick();
    req_valid = 1'b0;
    if (we) begin
      if ((a >> 6) < LINES) model_mem[a[11:6]] = v;
`ifdef LLC_RESP_WRITE_ACK_EN
      exp_addr.push_back(a); exp_val.push_back(v);
`endif
    end else begin
      exp_addr.push_back(a); exp_val.push_back(model_read(a));
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!resp_valid && n < 100) begin tick(); n++; end
  endtask

  task automatic get_resp(input string tag);
    int n;
    logic [63:0] ea;
    logic [LW-1:0] ev;
    wait_valid(n);
    ea = exp_addr.pop_front();
    ev = exp_val.pop_front();
    check({tag, "_valid"}, resp_valid, 1);
    check({tag, "_addr"}, resp_addr, ea);
    check({tag, "_value"}, resp_value, ev);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_addr.size() > 0) get_resp(tag);
  endtask

  initial begin
    int n;
    logic [LW-1:0] v, v2;
    logic [63:0] a;
    logic we;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_value = '0;
    resp_ready = 1'b0; init_we = 1'b0; init_line = '0; init_value = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_valid", resp_valid, 0);
    check("rst_ready", req_ready, 1);
    check("rst_addr", resp_addr, 0);
    check("rst_value", resp_value, 0);

    for (int l = 0; l < LINES; l++) begin
      v = rand_line();
      if (l == 0) v[31:0] = 32'hF840_0000;
      do_init(l, v);
    end

    // Idle-to-response latency and first-line byte order
    send_req(64'h0, 1'b0, '0);
    wait_valid(n);
    check("latency", n, LAT + 2);
    check("line0_low_word", resp_value[31:0], 32'hF840_0000);
    get_resp("read0");

    send_req(64'h44, 1'b0, '0);
    get_resp("read44");

    // Backpressure: response held stable across 10 stalled cycles
    send_req(64'h240, 1'b0, '0);
    wait_valid(n);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_valid", resp_valid, 1);
      check("stall_addr", resp_addr, exp_addr[0]);
      check("stall_value", resp_value, exp_val[0]);
    end
    get_resp("stall_release");
    check("idle_after_release", resp_valid, 0);

    // Queue fills to depth while a response is stalled
    send_req(64'h300, 1'b0, '0);
    wait_valid(n);
    send_req(64'h340, 1'b0, '0);
    send_req(64'h380, 1'b0, '0);
    check("ready_drops_when_full", req_ready, 0);
    get_resp("bp_a");
    send_req(64'h3C0, 1'b0, '0);
    drain("bp_order");

    // Write then read of the same line
    v = {64{8'hAA}};
    send_req(64'h80, 1'b1, v);
    send_req(64'h80, 1'b0, '0);
    check("write_model_line2", model_read(64'h80), {64{8'hAA}});
    drain("wr_rd");
    repeat (10) tick();
    check("no_extra_resp", resp_valid, 0);

    // Read returns contents at capture time, not at acceptance
    send_req(64'hC0, 1'b0, '0);
    tick();
    v = rand_line();
    do_init(3, v);
    exp_val[exp_val.size() - 1] = v;
    get_resp("late_init");

    // Same-cycle init write and request write to one line: request wins
    v = rand_line();
    v2 = rand_line();
    send_req(64'h1C0, 1'b1, v);
    do_init(7, v2);
    model_mem[7] = v;
    repeat (3) tick();
    drain("collide_ack");
    send_req(64'h1C8, 1'b0, '0);
    get_resp("collide_read");

    for (int i = 0; i < 24; i++) begin
      we = ($urandom_range(0, 3) == 0);
      a = rand_addr();
      send_req(a, we, rand_line());
      if (!we && $urandom_range(0, 1) == 1) send_req(rand_addr(), 1'b0, '0);
      repeat (3) tick();
      drain("rnd");
      if ($urandom_range(0, 2) == 0) do_init($urandom_range(0, LINES - 1), rand_line());
    end

    send_req(64'h1000, 1'b0, '0);
    check("oob_model_zero", exp_val[exp_val.size() - 1], '0);
    get_resp("oob_read");

    // Reset mid-WAIT drops the read; the already-popped write survives
    v = rand_line();
    send_req(64'h140, 1'b1, v);
    send_req(64'h140, 1'b0, '0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_addr.delete();
    exp_val.delete();
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_addr", resp_addr, 0);
    check("mid_rst_value", resp_value, 0);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (resp_valid) n++;
    end
    check("no_resp_after_rst", n, 0);
    send_req(64'h140, 1'b0, '0);
    check("write_kept_model", exp_val[0], v);
    get_resp("write_kept");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/llc_responder.md
LLC_RESPONDER -- requirements
Module: llc_responder

Interface
REQ-001 SHALL have parameter CACHE_LINE_BYTES, default 64: line size in bytes; line data width is CACHE_LINE_BYTES*8 = 512.
REQ-002 SHALL have parameter MEM_LINES, default 64: number of backing-store lines (4096 B).
REQ-003 SHALL have parameter LATENCY, default 5, legal range 1..255: wait-state cycles per request.
REQ-004 SHALL have parameter REQ_Q_DEPTH, default 2: request FIFO entries.
REQ-005 clk_in  input  1  single clock; all logic on posedge.
REQ-006 rst_in  input  1  reset, synchronous, active-high.
REQ-007 req_valid_in  input  1  frontend line request valid (frontend lc_valid_out).
REQ-008 req_ready_out  output  1  responder can accept a request (frontend lc_ready_in).
REQ-009 req_addr_in  input  64  request byte address.
REQ-010 req_we_in  input  1  request is a line write.
REQ-011 req_value_in  input  512  write data, byte i in bits [8i+7:8i].
REQ-012 resp_valid_out  output  1  response line valid (frontend lc_valid_in).
REQ-013 resp_ready_in  input  1  frontend accepts response (frontend lc_ready_out).
REQ-014 resp_addr_out  output  64  request address of the response, unmodified.
REQ-015 resp_value_out  output  512  response line data.
REQ-016 init_we_in  input  1  preload write strobe.
REQ-017 init_line_in  input  $clog2(MEM_LINES)  preload line index.
REQ-018 init_value_in  input  512  preload line data.

Function
REQ-019 Request accepted on a posedge with req_valid_in && req_ready_out; req_ready_out = FIFO not full.
REQ-020 FIFO in order; simultaneous push and pop when full is not allowed (ready already low); push and pop in the same cycle otherwise both take effect.
REQ-021 FSM states: IDLE, WAIT, SEND.
REQ-022 IDLE with FIFO non-empty: pop head, load counter = LATENCY, -> WAIT; FIFO empty: stay IDLE.
REQ-023 WAIT: decrement counter each cycle; on counter reaching 0 capture line, -> SEND.
REQ-024 Line index = req_addr[63:6]; index >= MEM_LINES: read returns all zeros, write is dropped.
REQ-025 Write performed at pop (entry to WAIT), so a later queued read of the same line returns the new data.
REQ-026 SEND: resp_valid_out = 1, resp_addr_out / resp_value_out held stable until resp_ready_in; on handshake -> IDLE.
REQ-027 With empty FIFO, FSM in IDLE, and no backpressure, resp_valid_out rises exactly LATENCY+2 cycles after the accepting posedge.
REQ-028 Read response data is the line contents at capture time (REQ-023), not at acceptance.
REQ-029 init_we_in writes init_value_in into line init_line_in in any state, in one cycle.
REQ-030 Same-cycle init write and request write (REQ-025) to the same line: the request write wins.
REQ-031 resp_valid_out is never asserted in IDLE or WAIT.

Reset
REQ-032 rst_in clears FIFO pointers and count, FSM -> IDLE, and the counter -> 0; outputs the following posedge: resp_valid_out = 0, resp_addr_out = 0, resp_value_out = 0, req_ready_out = 1.
REQ-033 Reset mid-WAIT or mid-SEND drops in-flight and queued requests; writes already performed remain.
REQ-034 Backing-store contents are not reset.

Configuration
REQ-035 Macro LLC_RESP_WRITE_ACK_EN defined: write requests traverse WAIT/SEND and return a response with resp_value_out = written data.
REQ-036 Macro LLC_RESP_WRITE_ACK_EN undefined: write is performed at pop, FSM returns to IDLE the next cycle, and no response is issued.

Verification
REQ-037 Preload line 0 with bytes 0x00,0x00,0x40,0xF8,...; read addr 0x0 with resp_ready_in = 1 -> resp_valid_out at accept+7 (LATENCY 5), resp_addr_out = 0x0, resp_value_out[31:0] = 0xF8400000.
REQ-038 Read addr 0x44 -> resp_addr_out = 0x44, resp_value_out = line 1 contents.
REQ-039 Hold resp_ready_in = 0 for 10 cycles -> resp_valid_out and data stable throughout; handshake on cycle 11 -> IDLE.
REQ-040 Issue 3 back-to-back reads during backpressure -> req_ready_out drops after 2; responses return in order.
REQ-041 Write 0xAA.. to 0x80, then read 0x80 -> read returns 0xAA..; with LLC_RESP_WRITE_ACK_EN, the write ack arrives first; without it, only one response is issued.
REQ-042 Read addr 0x1000 -> zero line; assert rst_in mid-WAIT -> no response, and req_ready_out = 1 after reset.
